// File: rtl/rms_peak_meter.sv
// RMS and peak meter for a 12-bit offset-binary sample stream.
// Each window of 2^LOG2N strobed samples yields a mean square and a peak |X-2048|.
// A bit-serial square-root engine turns the mean square into an RMS value while
// the next window keeps accumulating in parallel.
module rms_peak_meter #(
    parameter int LOG2N = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [11:0] X,
    output logic [11:0] RMS,
    output logic [11:0] PIC,
    output logic        ok_SQRT,
    output logic        Tmes,
    output logic        busy
);

    localparam int AW = 23 + LOG2N;

    typedef enum logic [1:0] {
        IDLE,
        SQRT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_sum;
    logic [11:0]       peak;
    logic [11:0]       pend_peak;
    logic [11:0]       mag;
    logic [23:0]       sq_full;
    logic [LOG2N-1:0]  cnt;
    logic              win_close;
    logic              accept_new;
    logic              start_req;
    logic [22:0]       operand;
    logic [22:0]       mean;

    logic [23:0]       rad;
    logic [13:0]       rem;
    logic [13:0]       rem_next;
    logic [15:0]       rem_shift;
    logic [15:0]       trial;
    logic              root_bit;
    logic [11:0]       root;
    logic [3:0]        iter;

    // Sample magnitude, square, running sum, window-close detection and one sqrt step
    always_comb begin
        mag        = X[11] ? {1'b0, X[10:0]} : (12'd2048 - X);
        sq_full    = {12'd0, mag} * {12'd0, mag};
        acc_sum    = acc + AW'(sq_full);
        mean       = acc_sum[LOG2N +: 23];
        win_close  = ce && (cnt == '1);
        accept_new = win_close && (state == IDLE) && !start_req;
        rem_shift  = {rem, rad[23:22]};
        trial      = {2'b00, root, 2'b01};
        root_bit   = (rem_shift >= trial);
        rem_next   = root_bit ? 14'(rem_shift - trial) : 14'(rem_shift);
    end

    // State register of the sqrt sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the engine starts the cycle after an accepted window close
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = SQRT;
                end
            end
            SQRT: begin
                busy = 1'b1;
                if (iter == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window accumulation; a close restarts the window and hands the result over only if the engine is free
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            peak      <= '0;
            cnt       <= '0;
            operand   <= '0;
            pend_peak <= '0;
            start_req <= 1'b0;
            Tmes      <= 1'b0;
        end else begin
            if (state == IDLE && start_req) begin
                start_req <= 1'b0;
            end
            if (ce) begin
                cnt <= cnt + 1'b1;
                if (win_close) begin
                    acc  <= '0;
                    peak <= '0;
                    Tmes <= ~Tmes;
                    if (accept_new) begin
                        operand   <= mean;
                        pend_peak <= (mag > peak) ? mag : peak;
                        start_req <= 1'b1;
                    end
                end else begin
                    acc <= acc_sum;
                    if (mag > peak) begin
                        peak <= mag;
                    end
                end
            end
        end
    end

    // Restoring square root, two radicand bits and one root bit per clock, then publish results
    always_ff @(posedge clk) begin
        if (rst) begin
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            iter    <= '0;
            RMS     <= '0;
            PIC     <= '0;
            ok_SQRT <= 1'b0;
        end else begin
            ok_SQRT <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        rad  <= {1'b0, operand};
                        rem  <= '0;
                        root <= '0;
                        iter <= 4'd11;
                    end
                end
                SQRT: begin
                    rem  <= rem_next;
                    root <= {root[10:0], root_bit};
                    rad  <= {rad[21:0], 2'b00};
                    iter <= iter - 4'd1;
                end
                DONE: begin
                    RMS     <= root;
                    PIC     <= pend_peak;
                    ok_SQRT <= 1'b1;
                end
                default: begin
                    ok_SQRT <= 1'b0;
                end
            endcase
        end
    end

endmodule
